addsub_chunked: RTL and testbench

Multi-cycle, parametrised two's-complement adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock, using a registered carry chain. It is the parametrised successor to the team's 32-bit combinational signed/unsigned adder/subtractor. It adds selectable signed/unsigned flag semantics, a valid/ready handshake on both sides, and a configurable area/latency trade-off. It sits between an operand source (register file or decoder stage) and a result consumer that may apply backpressure.

---
 rtl/addsub_chunked.sv | 111 +++++++++++
 tb/tb_addsub_chunked.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_chunked.sv
// rtl/addsub_chunked.sv - multi-cycle chunked add/sub with registered carry chain
// Operands shift right CHUNK bits per RUN cycle; sums shift in from the top of result.
module addsub_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             a_msb, b_msb;
  logic             op_q, sgn_q, cy_q;
  logic [CW-1:0]    k_q;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] res_nxt;
  logic             last, carry_nxt, sovf;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Low chunk of the shifted operands is always chunk k; finished result ends up aligned after N shifts
  always_comb begin
    last      = (k_q == CW'(N - 1));
    sum       = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};
    res_nxt   = (result >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    carry_nxt = op_q ? ~sum[CHUNK] : sum[CHUNK];
    sovf      = (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      op_q     <= 1'b0;
      sgn_q    <= 1'b0;
      cy_q     <= 1'b0;
      k_q      <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          a_q    <= a;
          b_q    <= op ? ~b : b;
          a_msb  <= a[WIDTH-1];
          b_msb  <= op ? ~b[WIDTH-1] : b[WIDTH-1];
          op_q   <= op;
          sgn_q  <= is_signed;
          cy_q   <= op;
          result <= '0;
          k_q    <= '0;
        end
        RUN: begin
          a_q    <= a_q >> CHUNK;
          b_q    <= b_q >> CHUNK;
          result <= res_nxt;
          cy_q   <= sum[CHUNK];
          k_q    <= k_q + CW'(1);
          if (last) begin
            carry    <= carry_nxt;
            overflow <= sgn_q ? sovf : carry_nxt;
            zero     <= ~|res_nxt;
            negative <= sgn_q & res_nxt[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_chunked.sv
// tb/tb_addsub_chunked.sv - directed table, backpressure, reset and random streams
// Instances: 0 = CHUNK 8, 1 = CHUNK 32, 2 = CHUNK 1 (all WIDTH 32).
module tb_addsub_chunked;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv[3], ir[3], ovl[3], ordy[3], opv[3], sgv[3];
  logic        cyv[3], ofv[3], zrv[3], ngv[3], bzv[3];
  logic [31:0] av[3], bv[3], rs[3];

  int n_chk = 0;
  int n_fail = 0;
  int lat_exp[3] = '{4, 1, 32};

  always #5 clk = ~clk;

  addsub_chunked #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .op(opv[0]), .is_signed(sgv[0]), .out_valid(ovl[0]), .out_ready(ordy[0]), .result(rs[0]),
    .carry(cyv[0]), .overflow(ofv[0]), .zero(zrv[0]), .negative(ngv[0]), .busy(bzv[0]));

  addsub_chunked #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .op(opv[1]), .is_signed(sgv[1]), .out_valid(ovl[1]), .out_ready(ordy[1]), .result(rs[1]),
    .carry(cyv[1]), .overflow(ofv[1]), .zero(zrv[1]), .negative(ngv[1]), .busy(bzv[1]));

  addsub_chunked #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2]), .b(bv[2]),
    .op(opv[2]), .is_signed(sgv[2]), .out_valid(ovl[2]), .out_ready(ordy[2]), .result(rs[2]),
    .carry(cyv[2]), .overflow(ofv[2]), .zero(zrv[2]), .negative(ngv[2]), .busy(bzv[2]));

  typedef struct {
    logic [31:0] a, b;
    logic        op, sg;
    logic [31:0] res;
    logic        cy, ovf, zr, ng;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Reference: plain 33-bit and 64-bit signed arithmetic
  function automatic logic [35:0] model(input logic [31:0] a, b, input logic op, sg);
    logic [32:0] w;
    longint      s;
    logic        cy, sovf;
    w    = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    cy   = op ? (a < b) : w[32];
    s    = op ? (longint'($signed(a)) - longint'($signed(b)))
              : (longint'($signed(a)) + longint'($signed(b)));
    sovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {w[31:0], cy, sg ? sovf : cy, w[31:0] == 32'd0, sg & w[31]};
  endfunction

  // Issue one op on instance i, hold out_ready low for 'hold' cycles after out_valid
  task automatic run_op(input int i, input logic [31:0] a_i, b_i, input logic op_i, sg_i,
                        input int hold, input bit pulse,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    int t = 0;
    @(negedge clk);
    while (!ir[i] && t < 200) begin @(negedge clk); t++; end
    if (!ir[i]) timeout($sformatf("in_ready[%0d]", i));
    av[i] = a_i; bv[i] = b_i; opv[i] = op_i; sgv[i] = sg_i; iv[i] = 1'b1;
    @(negedge clk);
    iv[i] = 1'b0; av[i] = $urandom; bv[i] = $urandom; opv[i] = ~op_i; sgv[i] = ~sg_i;
    lat = 0;
    while (!ovl[i] && lat < 100) begin @(negedge clk); lat++; end
    if (!ovl[i]) timeout($sformatf("out_valid[%0d]", i));
    chk($sformatf("busy[%0d]", i), 32'(bzv[i]), 32'd1);
    r = rs[i];
    f = {cyv[i], ofv[i], zrv[i], ngv[i]};
    for (int h = 0; h < hold; h++) begin
      if (pulse && h == 1) begin iv[i] = 1'b1; av[i] = 32'h1; bv[i] = 32'h1; end
      if (h == 2) iv[i] = 1'b0;
      @(negedge clk);
      chk($sformatf("hold res[%0d]", i), rs[i], r);
      chk($sformatf("hold flags[%0d]", i), 32'({cyv[i], ofv[i], zrv[i], ngv[i]}), 32'(f));
      chk($sformatf("hold in_ready[%0d]", i), 32'(ir[i]), 32'd0);
      chk($sformatf("hold out_valid[%0d]", i), 32'(ovl[i]), 32'd1);
    end
    iv[i] = 1'b0;
    ordy[i] = 1'b1;
    @(negedge clk);
    ordy[i] = 1'b0;
    chk($sformatf("post out_valid[%0d]", i), 32'(ovl[i]), 32'd0);
    chk($sformatf("post in_ready[%0d]", i), 32'(ir[i]), 32'd1);
  endtask

  task automatic rand_stream(input int i, input int n);
    logic [31:0] a, b, r;
    logic        op, sg;
    logic [3:0]  f;
    logic [35:0] m;
    logic [31:0] corner[4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    int          lat;
    for (int k = 0; k < n; k++) begin
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      op = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      run_op(i, a, b, op, sg, $urandom_range(0, 2), 1'b0, r, f, lat);
      m = model(a, b, op, sg);
      chk($sformatf("rand res[%0d] %h %s %h", i, a, op ? "-" : "+", b), r, m[35:4]);
      chk($sformatf("rand flags[%0d] %h %s %h s=%0d", i, a, op ? "-" : "+", b, sg),
          32'(f), 32'(m[3:0]));
      chk($sformatf("rand latency[%0d]", i), 32'(lat), 32'(lat_exp[i]));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
  endtask

  vec_t        vt[8];
  logic [31:0] r;
  logic [3:0]  f;
  int          lat;

  initial begin
    vt[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[1] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5] = '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; av[i] = '0; bv[i] = '0; opv[i] = 1'b0; sgv[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset in_ready[%0d]", i), 32'(ir[i]), 32'd1);
      chk($sformatf("reset busy[%0d]", i), 32'(bzv[i]), 32'd0);
      chk($sformatf("reset out_valid[%0d]", i), 32'(ovl[i]), 32'd0);
      chk($sformatf("reset result[%0d]", i), rs[i], 32'd0);
      chk($sformatf("reset flags[%0d]", i), 32'({cyv[i], ofv[i], zrv[i], ngv[i]}), 32'd0);
    end
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_op(0, vt[v].a, vt[v].b, vt[v].op, vt[v].sg, 0, 1'b0, r, f, lat);
      chk($sformatf("vec%0d res", v), r, vt[v].res);
      chk($sformatf("vec%0d flags", v), 32'(f), 32'({vt[v].cy, vt[v].ovf, vt[v].zr, vt[v].ng}));
      chk($sformatf("vec%0d latency", v), 32'(lat), 32'd4);
    end

    // Backpressure with an in_valid pulse that must be ignored in DONE
    run_op(0, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 5, 1'b1, r, f, lat);
    chk("bp res", r, 32'h33333333);
    chk("bp flags", 32'(f), 32'd0);
    @(negedge clk);
    chk("bp no extra op busy", 32'(bzv[0]), 32'd0);

    // Reset after two chunk cycles
    @(negedge clk);
    av[0] = 32'hFFFFFFFF; bv[0] = 32'h1; opv[0] = 1'b0; sgv[0] = 1'b0; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun out_valid", 32'(ovl[0]), 32'd0);
    chk("midrun in_ready", 32'(ir[0]), 32'd1);
    chk("midrun result", rs[0], 32'd0);
    chk("midrun flags", 32'({cyv[0], ofv[0], zrv[0], ngv[0]}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 0, 1'b0, r, f, lat);
    chk("after reset res", r, 32'd7);
    chk("after reset flags", 32'(f), 32'd0);

    fork
      rand_stream(0, 200);
      rand_stream(1, 1000);
      rand_stream(2, 1000);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
